gcd_unit: RTL and testbench

Self-contained, parametrised GCD engine. It merges the subtractive-GCD datapath (A/B registers, subtractor, comparator, load mux) with its controller FSM. Operands enter over a valid/ready handshake and results leave over a valid/ready handshake with back-pressure. It adds zero-operand handling, an iteration counter and a busy flag; the previous datapath-only block had none of these.

---
 rtl/gcd_unit.sv | 120 ++++++++++++
 tb/tb_gcd_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_unit.sv
// Subtractive GCD engine: operand/result valid-ready handshakes, zero-operand
// handling and a saturating iteration counter.
module gcd_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_out,
  output logic             zero_flag,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   gcd_q, gcd_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic               zero_q, zero_d;

  logic               a_zero, b_zero, a_eq_b, a_gt_b;
  logic [WIDTH-1:0]   diff_ab, diff_ba;
  logic [CNT_W-1:0]   iter_inc;

  assign a_zero  = (a_q == '0);
  assign b_zero  = (b_q == '0);
  assign a_eq_b  = (a_q == b_q);
  assign a_gt_b  = (a_q > b_q);
  // Only the difference with the larger operand as minuend is ever used.
  assign diff_ab = a_q - b_q;
  assign diff_ba = b_q - a_q;
  // Counter holds at all-ones instead of wrapping.
  assign iter_inc = (iter_q == '1) ? iter_q : iter_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    iter_d  = iter_q;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          iter_d  = '0;
          state_d = StCalc;
        end
      end

      StCalc: begin
        if (a_zero || b_zero) begin
          gcd_d   = a_q | b_q;
          zero_d  = a_zero && b_zero;
          state_d = StDone;
        end else if (a_eq_b) begin
          gcd_d   = a_q;
          zero_d  = 1'b0;
          state_d = StDone;
        end else if (a_gt_b) begin
          a_d    = diff_ab;
          iter_d = iter_inc;
        end else begin
          b_d    = diff_ba;
          iter_d = iter_inc;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
    end
  end

  // in_ready is gated by rst so nothing looks acceptable while reset is held.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign gcd_out   = gcd_q;
  assign iter_out  = iter_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Bench for gcd_unit: a 16-bit-counter instance and an 8-bit-counter instance share
// stimulus; results are checked against a Euclid-quotient reference model.
module tb_gcd_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  logic        in_ready, out_valid, zero_flag, busy;
  logic [15:0] gcd_out, iter_out;
  logic        in_ready8, out_valid8, zero_flag8, busy8;
  logic [15:0] gcd_out8;
  logic [7:0]  iter_out8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gcd_unit #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in),
    .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready), .gcd_out(gcd_out),
    .iter_out(iter_out), .zero_flag(zero_flag), .busy(busy)
  );

  gcd_unit #(.WIDTH(16), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .a_in(a_in),
    .b_in(b_in), .out_valid(out_valid8), .out_ready(out_ready), .gcd_out(gcd_out8),
    .iter_out(iter_out8), .zero_flag(zero_flag8), .busy(busy8)
  );

  // Subtraction count derived from Euclid quotients: a run of q subtractions per
  // division step, one fewer on the step that lands on equal operands.
  function automatic void model(input int unsigned a, input int unsigned b,
                                output int unsigned g, output int unsigned n,
                                output bit zf);
    int unsigned x, y, q, r;
    n  = 0;
    zf = (a == 0) && (b == 0);
    if (a == 0 || b == 0) begin
      g = a | b;
    end else begin
      x = a;
      y = b;
      while (x != y) begin
        if (x > y) begin
          q = x / y; r = x % y;
          if (r == 0) begin n += q - 1; x = y; end
          else begin n += q; x = r; end
        end else begin
          q = y / x; r = y % x;
          if (r == 0) begin n += q - 1; y = x; end
          else begin n += q; y = r; end
        end
      end
      g = x;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a pair and passes the accepting edge; unit is expected to be idle.
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles counted with the accepting edge as cycle 1; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 70000) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, gcd_out, iter_out, zero_flag} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b gcd=%0d iter=%0d zf=%b, want all 0",
               in_ready, out_valid, busy, gcd_out, iter_out, zero_flag);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    start(16'd12, 16'd8);
    wait_done(lat);
    n_checks++;
    if (lat !== 4 || gcd_out !== 16'd4 || iter_out !== 16'd2 || zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_12_8: lat=%0d gcd=%0d iter=%0d zf=%b, want 4 4 2 0",
               lat, gcd_out, iter_out, zero_flag);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_drop: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_corners();
    logic [15:0] ta [4] = '{16'd7, 16'd0, 16'd0, 16'd9};
    logic [15:0] tb [4] = '{16'd7, 16'd9, 16'd0, 16'd0};
    int unsigned g, n;
    bit zf;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model(ta[i], tb[i], g, n, zf);
      start(ta[i], tb[i]);
      wait_done(lat);
      n_checks++;
      if (lat !== int'(n + 2) || gcd_out !== g[15:0] || iter_out !== n[15:0] ||
          zero_flag !== zf) begin
        n_fail++;
        $display("FAIL corner_%0d_%0d: lat=%0d gcd=%0d iter=%0d zf=%b, want %0d %0d %0d %b",
                 ta[i], tb[i], lat, gcd_out, iter_out, zero_flag, n + 2, g, n, zf);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    start(16'd48, 16'd18);
    wait_done(lat);
    n_checks++;
    if (lat !== 6) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d want 6", lat);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({out_valid, in_ready, busy, gcd_out, iter_out} !== {3'b101, 16'd6, 16'd4}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b busy=%b gcd=%0d iter=%0d, want 1 0 1 6 4",
                 i, out_valid, in_ready, busy, gcd_out, iter_out);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_long();
    int lat;
    out_ready = 1'b1;
    start(16'd1, 16'd65535);
    wait_done(lat);
    n_checks++;
    if (lat !== 65536 || gcd_out !== 16'd1 || iter_out !== 16'd65534) begin
      n_fail++;
      $display("FAIL long_w16: lat=%0d gcd=%0d iter=%0d, want 65536 1 65534",
               lat, gcd_out, iter_out);
    end
    n_checks++;
    if (out_valid8 !== 1'b1 || gcd_out8 !== 16'd1 || iter_out8 !== 8'd255) begin
      n_fail++;
      $display("FAIL long_sat8: vld=%b gcd=%0d iter=%0d, want 1 1 255",
               out_valid8, gcd_out8, iter_out8);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    start(16'd1, 16'd1000);
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, gcd_out, iter_out, zero_flag,
         in_ready8, out_valid8, busy8, gcd_out8, iter_out8, zero_flag8} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%b vld=%b busy=%b gcd=%0d iter=%0d zf=%b, want all 0",
               in_ready, out_valid, busy, gcd_out, iter_out, zero_flag);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
    start(16'd35, 16'd21);
    wait_done(lat);
    n_checks++;
    if (gcd_out !== 16'd7 || iter_out !== 16'd3 || lat !== 5) begin
      n_fail++;
      $display("FAIL after_reset_35_21: gcd=%0d iter=%0d lat=%0d, want 7 3 5",
               gcd_out, iter_out, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned g, n;
    bit zf;
    int lat;
    out_ready = 1'b1;
    a_in = 16'd100;
    b_in = 16'd75;
    in_valid = 1'b1;
    tick();
    // Second pair presented while the first is still computing.
    a_in = 16'd17;
    b_in = 16'd5;
    wait_done(lat);
    n_checks++;
    if (gcd_out !== 16'd25 || iter_out !== 16'd3 || lat !== 5) begin
      n_fail++;
      $display("FAIL b2b_first: gcd=%0d iter=%0d lat=%0d, want 25 3 5", gcd_out, iter_out, lat);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: vld=%b rdy=%b busy=%b, want 0 1 0",
               out_valid, in_ready, busy);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_accept: busy=%b rdy=%b, want 1 0", busy, in_ready);
    end
    model(17, 5, g, n, zf);
    wait_done(lat);
    n_checks++;
    if (gcd_out !== g[15:0] || iter_out !== n[15:0] || lat !== int'(n + 2)) begin
      n_fail++;
      $display("FAIL b2b_second: gcd=%0d iter=%0d lat=%0d, want %0d %0d %0d",
               gcd_out, iter_out, lat, g, n, n + 2);
    end
    tick();
  endtask

  task automatic test_random();
    int unsigned a, b, g, n, n8;
    bit zf;
    int lat, stall;
    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) a = 0;
      if ($urandom_range(0, 7) == 0) b = 0;
      stall = $urandom_range(0, 3);
      model(a, b, g, n, zf);
      n8 = (n > 255) ? 255 : n;
      out_ready = 1'b0;
      start(a[15:0], b[15:0]);
      wait_done(lat);
      n_checks++;
      if (lat !== int'(n + 2) || gcd_out !== g[15:0] || iter_out !== n[15:0] ||
          zero_flag !== zf || gcd_out8 !== g[15:0] || iter_out8 !== n8[7:0]) begin
        n_fail++;
        $display("FAIL rand_%0d_%0d: lat=%0d gcd=%0d iter=%0d zf=%b iter8=%0d, want %0d %0d %0d %b %0d",
                 a, b, lat, gcd_out, iter_out, zero_flag, iter_out8, n + 2, g, n, zf, n8);
      end
      repeat (stall) tick();
      n_checks++;
      if (out_valid !== 1'b1 || gcd_out !== g[15:0] || iter_out !== n[15:0]) begin
        n_fail++;
        $display("FAIL rand_stall_%0d_%0d: vld=%b gcd=%0d iter=%0d, want 1 %0d %0d",
                 a, b, out_valid, gcd_out, iter_out, g, n);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_handshake_%0d_%0d: vld=%b rdy=%b, want 0 1", a, b, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_long();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
